// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: op encodings, FSM states
// and flag bit positions within the {C,Z,N} vector.
package alu_pkg;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] AND = 2'b01;
    localparam logic [1:0] OR  = 2'b10;
    localparam logic [1:0] ADC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        EXEC = 2'b10,
        WB   = 2'b11
    } state_t;

    localparam int C = 2;
    localparam int Z = 1;
    localparam int N = 0;

endpackage

// File: rtl/regfile8x8.sv
// General-purpose register file: async-reset array, one synchronous write
// port and two combinational read ports.
module regfile8x8 #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts one command, drives the external ALU
// from registers, then writes result and {C,Z,N} flags back.
//
// state | meaning
// IDLE  | ready for a command; command fields latched on accept
// READ  | register file read, ALU operand/op/carry-in registers loaded
// EXEC  | ALU evaluates; result and carry captured at the end
// WB    | done pulse; result and flags written at the end
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rs,
    input  logic                    cmd_use_imm,
    input  logic [DW-1:0]           cmd_imm,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [1:0]              alu_op,
    output logic                    alu_cin,
    input  logic [DW-1:0]           alu_result,
    input  logic [2:0]              alu_czn,
    output logic                    done,
    output logic [DW-1:0]           wb_data,
    output logic [2:0]              flags_czn,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DW-1:0]           dbg_data
);

    localparam int AW = $clog2(NREG);

    state_t        state;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs_q;
    logic          use_imm_q;
    logic [DW-1:0] imm_q;
    logic          carry_q;
    logic          accept;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] port_b_val;
    logic [AW-1:0] port_b_addr;
    logic          unused_czn;

    // Z and N are derived locally from the result, so the ALU's own copies are dropped.
    assign unused_czn = ^alu_czn[Z:N];

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // The second read port serves the rs operand during READ and debug otherwise.
    assign port_b_addr = (state == READ) ? rs_q : dbg_addr;
    assign dbg_data    = port_b_val;

    regfile8x8 #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (state == WB),
        .waddr   (rd_q),
        .wdata   (wb_data),
        .raddr_a (rd_q),
        .rdata_a (rd_val),
        .raddr_b (port_b_addr),
        .rdata_b (port_b_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= READ;
                READ:    state <= EXEC;
                EXEC:    state <= WB;
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= ADD;
            rd_q      <= '0;
            rs_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
        end else if (accept) begin
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            rs_q      <= cmd_rs;
            use_imm_q <= cmd_use_imm;
            imm_q     <= cmd_imm;
        end
    end

    // ADC is issued to the ALU as a plain ADD with the stored carry injected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= ADD;
            alu_cin <= 1'b0;
        end else if (state == READ) begin
            alu_a   <= rd_val;
            alu_b   <= use_imm_q ? imm_q : port_b_val;
            alu_op  <= (op_q == ADC) ? ADD : op_q;
            alu_cin <= (op_q == ADC) && flags_czn[C];
        end
    end

    // wb_data doubles as the captured result that is written back in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            wb_data <= '0;
            carry_q <= 1'b0;
        end else begin
            done <= (state == EXEC);
            if (state == EXEC) begin
                wb_data <= alu_result;
                carry_q <= alu_czn[C];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_czn <= 3'b000;
        end else if (state == WB) begin
            flags_czn[Z] <= (wb_data == '0);
            flags_czn[N] <= wb_data[DW-1];
            if (op_q == ADD || op_q == ADC) begin
                flags_czn[C] <= carry_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an attached ALU model, a reference
// register/flag model and a queue of expected writeback values.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_rd = 3'd0;
    logic [2:0] cmd_rs = 3'd0;
    logic       cmd_use_imm = 1'b0;
    logic [7:0] cmd_imm = 8'h00;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic       alu_cin;
    logic [7:0] alu_result;
    logic [2:0] alu_czn;
    logic       done;
    logic [7:0] wb_data;
    logic [2:0] flags_czn;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_r [8];
    logic       m_c;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs      (cmd_rs),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cin     (alu_cin),
        .alu_result  (alu_result),
        .alu_czn     (alu_czn),
        .done        (done),
        .wb_data     (wb_data),
        .flags_czn   (flags_czn),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Combinational ALU: 9-bit add with carry-in, bitwise AND/OR.
    logic [8:0] alu_r;
    always_comb begin
        alu_r = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        case (alu_op)
            2'b01:   alu_r = {1'b0, alu_a & alu_b};
            2'b10:   alu_r = {1'b0, alu_a | alu_b};
            default: ;
        endcase
    end
    assign alu_result = alu_r[7:0];
    assign alu_czn    = {alu_r[8], alu_r[7:0] == 8'h00, alu_r[7]};

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_c = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic ui, input logic [7:0] imm,
                             output logic [7:0] res, output logic [2:0] fl,
                             output logic [7:0] ea, output logic [7:0] eb,
                             output logic ecin, output logic [1:0] eop);
        logic [8:0] s;
        ea = m_r[rd];
        eb = ui ? imm : m_r[rs];
        ecin = 1'b0;
        eop = op;
        s = 9'd0;
        case (op)
            2'b00: begin s = {1'b0, ea} + {1'b0, eb}; m_c = s[8]; end
            2'b11: begin
                ecin = m_c; eop = 2'b00;
                s = {1'b0, ea} + {1'b0, eb} + {8'd0, m_c};
                m_c = s[8];
            end
            2'b01: s = {1'b0, ea & eb};
            default: s = {1'b0, ea | eb};
        endcase
        res = s[7:0];
        m_r[rd] = res;
        fl = {m_c, res == 8'h00, res[7]};
        exp_q.push_back(res);
    endtask

    task automatic scramble();
        cmd_op = 2'($urandom);
        cmd_rd = 3'($urandom);
        cmd_rs = 3'($urandom);
        cmd_use_imm = 1'($urandom);
        cmd_imm = 8'($urandom);
    endtask

    task automatic check_done_pop(input string tag);
        if (exp_q.size() > 0) chk(wb_data, exp_q.pop_front(), tag);
        else chk(done, 0, {tag, "_unexpected_done"});
    endtask

    // Issue one command from a negedge, follow it through to writeback.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic ui, input logic [7:0] imm, input string tag);
        logic [7:0] res, ea, eb;
        logic [2:0] ef;
        logic       ecin;
        logic [1:0] eop;
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs;
        cmd_use_imm = ui; cmd_imm = imm;
        n = 0;
        while (!cmd_ready && n < 16) begin @(negedge clk); n++; end
        chk(cmd_ready, 1, {tag, "_ready"});
        model_cmd(op, rd, rs, ui, imm, res, ef, ea, eb, ecin, eop);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble();
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 2) begin
                chk(alu_a, ea, {tag, "_alu_a"});
                chk(alu_b, eb, {tag, "_alu_b"});
                chk(alu_op, eop, {tag, "_alu_op"});
                chk(alu_cin, ecin, {tag, "_alu_cin"});
            end
        end while (!done && n < 8);
        chk(n, 3, {tag, "_latency"});
        if (done) check_done_pop({tag, "_wb_data"});
        @(negedge clk);
        chk(done, 0, {tag, "_done_width"});
        chk(cmd_ready, 1, {tag, "_ready_after"});
        chk(flags_czn, ef, {tag, "_flags"});
        dbg_addr = rd; #1;
        chk(dbg_data, res, {tag, "_reg"});
    endtask

    logic [1:0] s_op  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [2:0] s_rd  [4] = '{3'd1, 3'd7, 3'd7, 3'd7};
    logic [2:0] s_rs  [4] = '{3'd0, 3'd0, 3'd1, 3'd0};
    logic       s_ui  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] s_imm [4] = '{8'h10, 8'h33, 8'h00, 8'h0F};

    initial begin
        logic [7:0] r_d, a_d, b_d;
        logic [2:0] f_d;
        logic       c_d;
        logic [1:0] o_d;
        int k, last, dones, seen;
        model_reset();
        repeat (2) @(negedge clk);
        chk(cmd_ready, 1, "reset_ready");
        chk(done, 0, "reset_done");
        chk(flags_czn, 3'b000, "reset_flags");
        chk({alu_a, alu_b, alu_op, alu_cin}, 0, "reset_alu_regs");
        chk(wb_data, 0, "reset_wb_data");
        rst_n = 1'b1;
        @(negedge clk);
        chk(cmd_ready, 1, "post_reset_ready");
        dbg_addr = 3'd5; #1;
        chk(dbg_data, 0, "reset_reg");

        run_cmd(2'b10, 3'd1, 3'd0, 1'b1, 8'h00, "or_r1_00");
        chk(flags_czn, 3'b010, "or_r1_00_const");
        run_cmd(2'b10, 3'd1, 3'd0, 1'b1, 8'h7F, "or_r1_7f");
        run_cmd(2'b00, 3'd1, 3'd0, 1'b1, 8'h81, "add_r1_81");
        chk(flags_czn, 3'b110, "add_r1_81_const");
        run_cmd(2'b11, 3'd1, 3'd0, 1'b1, 8'h05, "adc_r1_05");
        chk(dbg_data, 8'h06, "adc_r1_05_const");
        run_cmd(2'b10, 3'd5, 3'd0, 1'b1, 8'hFF, "or_r5_ff");
        run_cmd(2'b00, 3'd5, 3'd0, 1'b1, 8'h01, "add_r5_01");
        run_cmd(2'b10, 3'd2, 3'd0, 1'b1, 8'hF0, "or_r2_f0");
        run_cmd(2'b10, 3'd3, 3'd0, 1'b1, 8'h8F, "or_r3_8f");
        run_cmd(2'b01, 3'd2, 3'd3, 1'b0, 8'h00, "and_r2_r3");
        chk(flags_czn, 3'b101, "and_keeps_c_const");
        repeat (3) @(negedge clk);
        chk(alu_b, 8'h8F, "alu_b_holds_idle");

        // cmd_valid held high; fields scrambled whenever the controller is busy.
        cmd_valid = 1'b1;
        k = 0; last = -1; dones = 0;
        for (int cyc = 0; cyc < 17; cyc++) begin
            if (done) begin
                dones++;
                check_done_pop("stream_wb_data");
            end
            if (cmd_ready) begin
                if (last >= 0) chk(cyc - last, 4, "stream_ready_period");
                last = cyc;
                if (k < 4) begin
                    cmd_op = s_op[k]; cmd_rd = s_rd[k]; cmd_rs = s_rs[k];
                    cmd_use_imm = s_ui[k]; cmd_imm = s_imm[k];
                    model_cmd(s_op[k], s_rd[k], s_rs[k], s_ui[k], s_imm[k], r_d, f_d, a_d, b_d, c_d, o_d);
                    k++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end else begin
                scramble();
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk(dones, 4, "stream_done_count");
        chk(exp_q.size(), 0, "stream_queue_empty");
        chk(flags_czn, f_d, "stream_flags");
        dbg_addr = 3'd7; #1;
        chk(dbg_data, m_r[7], "stream_r7");

        // Reset during EXEC abandons the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd4; cmd_use_imm = 1'b1; cmd_imm = 8'h10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(alu_b, 8'h10, "exec_alu_b_before_reset");
        rst_n = 1'b0; #1;
        model_reset();
        chk(cmd_ready, 1, "ready_in_reset");
        chk(done, 0, "done_in_reset");
        chk(alu_b, 0, "alu_b_in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(seen, 0, "no_done_after_reset");
        chk(cmd_ready, 1, "ready_after_reset");
        chk(flags_czn, 3'b000, "flags_after_reset");
        dbg_addr = 3'd4; #1;
        chk(dbg_data, 8'h00, "r4_after_reset");
        dbg_addr = 3'd1; #1;
        chk(dbg_data, 8'h00, "r1_after_reset");

        run_cmd(2'b00, 3'd4, 3'd0, 1'b1, 8'h10, "add_r4_post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that drives the 8-bit datapath ALU from the command side and consumes its result and flags. It accepts one command at a time over a valid/ready handshake and reads operands from an internal 8x8 register file. It drives the ALU operand, op and carry-in lines from registers, then writes the result and the C/Z/N flags back. It sits between the CPU control FSM and the ALU.

## Interface

Parameters:
- DW, 8: datapath width
- NREG, 8: register file depth (address width = 3)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, can accept
- cmd_op  in  2  00 ADD, 01 AND, 10 OR, 11 ADC (add with stored C)
- cmd_rd  in  3  destination and first-operand register
- cmd_rs  in  3  second-operand register
- cmd_use_imm  in  1  second operand = cmd_imm instead of R[cmd_rs]
- cmd_imm  in  8  immediate operand
- alu_a, alu_b  out  8 each  registered ALU operands
- alu_op  out  2  registered ALU op: 00 ADD, 01 AND, 10 OR
- alu_cin  out  1  registered ALU carry-in
- alu_result  in  8  ALU result
- alu_czn  in  3  ALU flags; only bit 2 (carry) is used
- done  out  1  one-cycle pulse on writeback
- wb_data  out  8  value written, valid while done=1
- flags_czn  out  3  stored {C,Z,N}
- dbg_addr  in  3  debug read address
- dbg_data  out  8  R[dbg_addr], combinational

## Operation

- FSM states: IDLE, READ, EXEC, WB.
- cmd_ready = (state==IDLE). A command is accepted on a rising edge with cmd_valid && cmd_ready.
- IDLE -> READ on accept. The command fields are latched.
- READ -> EXEC:
  - alu_a <= R[rd]
  - alu_b <= use_imm ? imm : R[rs]
  - alu_op <= (op==ADC) ? 00 : op
  - alu_cin <= (op==ADC) ? C : 0
- EXEC -> WB: alu_result and alu_czn[2] are captured into internal registers.
- WB -> IDLE:
  - R[rd] <= captured result; done=1; wb_data = captured result.
  - Z <= (result==0); N <= result[7]. The N flag is derived locally and alu_czn[0] and alu_czn[1] are ignored.
  - C <= captured carry only for ADD/ADC. AND/OR leave C unchanged.
- alu_* outputs hold their values between commands. They change only in READ.
- The register file is written only in WB. dbg_data reflects a write on the cycle after WB.
- Arithmetic is 8-bit wrap-around. The carry is the 9th bit from the ALU.
- cmd_valid is ignored outside IDLE, and the command fields may change freely then.
- Reset (async, rst_n=0):
  - state=IDLE; all R[i]=0; flags_czn=000; alu_a=alu_b=0; alu_op=00; alu_cin=0; done=0; wb_data=0.
  - Reset mid-command abandons the command: no writeback, no done.

## Timing

- Accept on edge T0. READ during T0..T1, EXEC during T1..T2, WB during T2..T3.
- done is high for exactly the cycle following edge T2.
- cmd_ready returns high after edge T3.
- Latency: 3 cycles from accept to done. Throughput: 1 command per 4 cycles.
- ALU inputs are stable for the full EXEC cycle. The ALU is combinational and needs no handshake.
- cmd_ready is high during and immediately after reset.
- A back-to-back command is accepted at the earliest on edge T3+1. It reads the value written at T3, so there is no hazard.

## Structure

- Shared package alu_pkg:
  - ALU op constants ADD=2'b00, AND=2'b01, OR=2'b10
  - command op constant ADC=2'b11
  - FSM state enum {IDLE, READ, EXEC, WB}
  - flag bit indices C=2, Z=1, N=0
- One sub-module: regfile8x8. It has an async-reset register array, one synchronous write port, and two combinational read ports (operand/debug muxed by FSM). The controller FSM stays in the top module.

## Test plan

- Reset, then preload via commands:
  - OR R1, imm 0x00 -> R1=0x00, Z=1, N=0, C=0.
  - OR R1, imm 0x7F -> R1=0x7F, flags 000.
- ADD R1, imm 0x81 with an ALU model attached -> R1=0x00, C=1, Z=1, N=0. done occurs 3 cycles after accept.
- After the step above, ADC R1, imm 0x05 -> alu_cin=1, R1=0x06, C=0, Z=0.
- AND R2=0xF0 with R3=0x8F (register operand) -> R2=0x80, N=1, C unchanged from the previous value.
- Hold cmd_valid=1 continuously -> cmd_ready pulses once every 4 cycles and exactly one command is accepted per pulse. Command fields changed during busy cycles have no effect.
- Assert rst_n=0 during EXEC of ADD R4, imm 0x10 -> no done; R4=0; flags 000; cmd_ready=1 after release.
